// File: rtl/uart_cmd_parser.sv
// Line parser for "R<addr hex><len hex><CR|LF>" read commands from uart_rx.
// Hands the decoded command to the flash read sequencer over valid/ready.
module uart_cmd_parser #(
    parameter int ADDR_W  = 24,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 7_200_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_read,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int ADDR_D = ADDR_W / 4;
    localparam int LEN_D  = LEN_W / 4;
    localparam int MAX_D  = (ADDR_D > LEN_D) ? ADDR_D : LEN_D;
    localparam int DCNT_W = $clog2(MAX_D + 1);
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, ADDR, LEN, TERM, OUT, ERR} state_t;

    state_t              state, state_n, cur;
    logic [DCNT_W-1:0]   dcnt, dcnt_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [LEN_W-1:0]    len_n;
    logic                valid_n, err_n;
    logic [1:0]          code_n;
    logic [TO_W-1:0]     idle_cnt;
    logic                counting, timeout;
    logic                is_hex, is_term, is_r;
    logic [3:0]          nib;

    always_comb begin
        is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_r    = (rx_data == 8'h52) || (rx_data == 8'h72);
        is_hex  = 1'b1;
        nib     = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39)
            nib = rx_data[3:0];
        else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66))
            nib = rx_data[3:0] + 4'd9;
        else
            is_hex = 1'b0;
    end

    assign rx_read  = rx_valid && !rst && (state != OUT);
    assign busy     = (state != IDLE);
    assign counting = (state == ADDR) || (state == LEN) || (state == TERM);
    assign timeout  = (TIMEOUT != 0) && counting && (idle_cnt == TO_LAST);

    // A timeout drops the partial line; any byte arriving on that same edge
    // is then handled as the first byte seen in IDLE.
    always_comb begin
        cur     = timeout ? IDLE : state;
        state_n = cur;
        dcnt_n  = dcnt;
        addr_n  = cmd_addr;
        len_n   = cmd_len;
        valid_n = cmd_valid;
        err_n   = 1'b0;
        code_n  = err_code;
        case (cur)
            IDLE: if (rx_valid) begin
                if (is_r) begin
                    state_n = ADDR;
                    addr_n  = '0;
                    dcnt_n  = '0;
                end else if (!is_term) begin
                    state_n = ERR;
                    if (!timeout) begin
                        err_n  = 1'b1;
                        code_n = 2'd1;
                    end
                end
            end
            ADDR: if (rx_valid) begin
                if (is_hex) begin
                    addr_n = ADDR_W'({cmd_addr, nib});
                    if (dcnt == DCNT_W'(ADDR_D - 1)) begin
                        state_n = LEN;
                        dcnt_n  = '0;
                    end else begin
                        dcnt_n = dcnt + DCNT_W'(1);
                    end
                end else begin
                    state_n = ERR;
                    err_n   = 1'b1;
                    code_n  = 2'd1;
                end
            end
            LEN: if (rx_valid) begin
                if (is_hex) begin
                    len_n = LEN_W'({cmd_len, nib});
                    if (dcnt == DCNT_W'(LEN_D - 1)) begin
                        state_n = TERM;
                        dcnt_n  = '0;
                    end else begin
                        dcnt_n = dcnt + DCNT_W'(1);
                    end
                end else begin
                    state_n = ERR;
                    err_n   = 1'b1;
                    code_n  = 2'd1;
                end
            end
            TERM: if (rx_valid) begin
                if (is_term) begin
                    state_n = OUT;
                    valid_n = 1'b1;
                end else begin
                    state_n = ERR;
                    err_n   = 1'b1;
                    code_n  = 2'd1;
                end
            end
            OUT: if (cmd_ready) begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
            ERR: if (rx_valid && is_term) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            err_n  = 1'b1;
            code_n = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dcnt      <= '0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state     <= state_n;
            dcnt      <= dcnt_n;
            cmd_addr  <= addr_n;
            cmd_len   <= len_n;
            cmd_valid <= valid_n;
            err       <= err_n;
            err_code  <= code_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rx_read || !counting || timeout)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TO_W'(1);
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: drives ASCII command lines and checks
// decoded commands, error strobes, back-pressure, timeout and reset.
module tb_uart_cmd_parser;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_read;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    int tests = 0;
    int fails = 0;

    int          err_cnt = 0;
    int          xfer_cnt = 0;
    logic [23:0] last_addr = '0;
    logic [7:0]  last_len = '0;

    uart_cmd_parser #(.ADDR_W(24), .LEN_W(8), .TIMEOUT(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_read   (rx_read),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe error strobes and command transfers away from the active edge
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (cmd_valid && cmd_ready) begin
            xfer_cnt++;
            last_addr = cmd_addr;
            last_len  = cmd_len;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Present one byte and hold it until the DUT consumes it; returns 1ns after that edge
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_read && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!rx_read) begin
            tests++; fails++;
            $display("[TB] FAIL send_byte %h: rx_read never asserted (got 0, required 1)", b);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h52; cmd_ready = 1'b1;
        idle(3);
        @(negedge clk);
        tests++; if (rx_read !== 1'b0) begin fails++; $display("[TB] FAIL reset_rx_read: got %b required 0", rx_read); end
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_cmd_valid: got %b required 0", cmd_valid); end
        tests++; if (cmd_addr !== 24'h0) begin fails++; $display("[TB] FAIL reset_cmd_addr: got %h required 000000", cmd_addr); end
        tests++; if (cmd_len !== 8'h0) begin fails++; $display("[TB] FAIL reset_cmd_len: got %h required 00", cmd_len); end
        tests++; if (err !== 1'b0 || err_code !== 2'd0) begin fails++; $display("[TB] FAIL reset_err: got %b/%0d required 0/0", err, err_code); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        @(posedge clk); #1;
        rx_valid = 1'b0; rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_cmd();
        int e0, x0;
        e0 = err_cnt; x0 = xfer_cnt;
        cmd_ready = 1'b1;
        send_str("R40001A10");
        send_byte(8'h0D);
        tests++; if (cmd_valid !== 1'b1) begin fails++; $display("[TB] FAIL good_valid: got %b required 1", cmd_valid); end
        tests++; if (cmd_addr !== 24'h40001A) begin fails++; $display("[TB] FAIL good_addr: got %h required 40001a", cmd_addr); end
        tests++; if (cmd_len !== 8'h10) begin fails++; $display("[TB] FAIL good_len: got %h required 10", cmd_len); end
        idle(1);
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("[TB] FAIL good_valid_drop: got %b required 0", cmd_valid); end
        idle(3);
        tests++; if (xfer_cnt - x0 !== 1) begin fails++; $display("[TB] FAIL good_xfers: got %0d required 1", xfer_cnt - x0); end
        tests++; if (err_cnt !== e0) begin fails++; $display("[TB] FAIL good_no_err: got %0d errs required 0", err_cnt - e0); end
    endtask

    task automatic test_lowercase_crlf();
        int e0, x0;
        e0 = err_cnt; x0 = xfer_cnt;
        cmd_ready = 1'b1;
        send_str("r4000ff00");
        send_byte(8'h0D);
        send_byte(8'h0A);
        idle(2);
        tests++; if (xfer_cnt - x0 !== 1) begin fails++; $display("[TB] FAIL lc_xfers: got %0d required 1", xfer_cnt - x0); end
        tests++; if (last_addr !== 24'h4000FF) begin fails++; $display("[TB] FAIL lc_addr: got %h required 4000ff", last_addr); end
        tests++; if (last_len !== 8'h00) begin fails++; $display("[TB] FAIL lc_len: got %h required 00", last_len); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL lc_busy: got %b required 0", busy); end
        tests++; if (err_cnt !== e0) begin fails++; $display("[TB] FAIL lc_no_err: got %0d errs required 0", err_cnt - e0); end
    endtask

    task automatic test_back_pressure();
        int bad_read, bad_hold, x0;
        bad_read = 0; bad_hold = 0;
        cmd_ready = 1'b0;
        send_str("R12345678");
        send_byte(8'h0D);
        x0 = xfer_cnt;
        rx_data = 8'h52; rx_valid = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (rx_read !== 1'b0) bad_read++;
            if (cmd_valid !== 1'b1 || cmd_addr !== 24'h123456 || cmd_len !== 8'h78) bad_hold++;
            @(posedge clk); #1;
        end
        tests++; if (bad_read !== 0) begin fails++; $display("[TB] FAIL bp_rx_read_low: got %0d cycles high required 0", bad_read); end
        tests++; if (bad_hold !== 0) begin fails++; $display("[TB] FAIL bp_cmd_stable: got %0d bad cycles required 0", bad_hold); end
        cmd_ready = 1'b1;
        @(negedge clk);
        tests++; if (rx_read !== 1'b0) begin fails++; $display("[TB] FAIL bp_no_read_on_xfer: got %b required 0", rx_read); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (rx_read !== 1'b1) begin fails++; $display("[TB] FAIL bp_read_after_xfer: got %b required 1", rx_read); end
        tests++; if (cmd_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_valid_after_xfer: got %b required 0", cmd_valid); end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL bp_r_consumed: busy got %b required 1", busy); end
        tests++; if (xfer_cnt - x0 !== 1) begin fails++; $display("[TB] FAIL bp_xfers: got %0d required 1", xfer_cnt - x0); end
        send_str("00000001");
        send_byte(8'h0D);
        idle(2);
        tests++; if (last_addr !== 24'h000000 || last_len !== 8'h01) begin fails++; $display("[TB] FAIL bp_follow_cmd: got %h/%h required 000000/01", last_addr, last_len); end
    endtask

    task automatic test_bad_char();
        int e0, x0;
        e0 = err_cnt; x0 = xfer_cnt;
        cmd_ready = 1'b1;
        send_str("R40G");
        tests++; if (err !== 1'b1 || err_code !== 2'd1) begin fails++; $display("[TB] FAIL bad_err: got %b/%0d required 1/1", err, err_code); end
        send_str("0010R4000001");
        send_byte(8'h0D);
        idle(2);
        tests++; if (err_cnt - e0 !== 1) begin fails++; $display("[TB] FAIL bad_err_once: got %0d required 1", err_cnt - e0); end
        tests++; if (xfer_cnt !== x0) begin fails++; $display("[TB] FAIL bad_discard: got %0d xfers required 0", xfer_cnt - x0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL bad_busy: got %b required 0", busy); end
        send_str("R40000001");
        send_byte(8'h0D);
        idle(2);
        tests++; if (xfer_cnt - x0 !== 1 || last_addr !== 24'h400000 || last_len !== 8'h01) begin fails++; $display("[TB] FAIL bad_recover: got %0d xfers %h/%h required 1 400000/01", xfer_cnt - x0, last_addr, last_len); end
        tests++; if (err_code !== 2'd1) begin fails++; $display("[TB] FAIL bad_code_held: got %0d required 1", err_code); end
    endtask

    task automatic test_timeout();
        int early, x0;
        early = 0;
        cmd_ready = 1'b1;
        send_str("R40");
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k < 100 && err !== 1'b0) early++;
        end
        tests++; if (early !== 0) begin fails++; $display("[TB] FAIL to_early: got %0d early strobes required 0", early); end
        tests++; if (err !== 1'b1 || err_code !== 2'd2) begin fails++; $display("[TB] FAIL to_err: got %b/%0d required 1/2", err, err_code); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL to_busy: got %b required 0", busy); end
        x0 = xfer_cnt;
        send_str("R0000AB05");
        send_byte(8'h0D);
        idle(2);
        tests++; if (xfer_cnt - x0 !== 1 || last_addr !== 24'h0000AB || last_len !== 8'h05) begin fails++; $display("[TB] FAIL to_recover: got %0d xfers %h/%h required 1 0000ab/05", xfer_cnt - x0, last_addr, last_len); end
    endtask

    task automatic test_too_many_digits();
        int e0, x0;
        e0 = err_cnt; x0 = xfer_cnt;
        cmd_ready = 1'b1;
        send_str("R40000001");
        tests++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL many_no_early_err: got %b required 0", err); end
        send_byte(8'h30);
        tests++; if (err !== 1'b1 || err_code !== 2'd1) begin fails++; $display("[TB] FAIL many_err: got %b/%0d required 1/1", err, err_code); end
        send_byte(8'h30);
        send_byte(8'h0D);
        idle(2);
        tests++; if (xfer_cnt !== x0 || err_cnt - e0 !== 1) begin fails++; $display("[TB] FAIL many_drop: got %0d xfers %0d errs required 0/1", xfer_cnt - x0, err_cnt - e0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL many_busy: got %b required 0", busy); end
    endtask

    task automatic test_mid_reset();
        int e0, x0;
        e0 = err_cnt; x0 = xfer_cnt;
        cmd_ready = 1'b1;
        send_str("R1234567");
        rst = 1'b1; idle(1); rst = 1'b0;
        tests++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_len: got busy %b valid %b required 0/0", busy, cmd_valid); end
        tests++; if (cmd_addr !== 24'h0) begin fails++; $display("[TB] FAIL rst_len_addr: got %h required 000000", cmd_addr); end
        cmd_ready = 1'b0;
        send_str("R12345678");
        send_byte(8'h0D);
        tests++; if (cmd_valid !== 1'b1) begin fails++; $display("[TB] FAIL rst_out_setup: got %b required 1", cmd_valid); end
        idle(3);
        rst = 1'b1; idle(1); rst = 1'b0;
        tests++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_out: got busy %b valid %b required 0/0", busy, cmd_valid); end
        cmd_ready = 1'b1;
        idle(2);
        tests++; if (err_cnt !== e0 || xfer_cnt !== x0) begin fails++; $display("[TB] FAIL rst_silent: got %0d errs %0d xfers required 0/0", err_cnt - e0, xfer_cnt - x0); end
        send_str("RABCDEF02");
        send_byte(8'h0A);
        idle(2);
        tests++; if (xfer_cnt - x0 !== 1 || last_addr !== 24'hABCDEF || last_len !== 8'h02) begin fails++; $display("[TB] FAIL rst_recover: got %0d xfers %h/%h required 1 abcdef/02", xfer_cnt - x0, last_addr, last_len); end
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0;
        test_reset();
        test_good_cmd();
        test_lowercase_crlf();
        test_back_pressure();
        test_bad_char();
        test_timeout();
        test_too_many_digits();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
